// File: rtl/ia_pkg.sv
// ----------------------------------------------------------------------------
// ia_pkg
// Types and helpers shared by the input-activation skew feeder and its
// per-lane delay line.
//   lane_tag_t    : qualifiers that travel with every lane element
//                   (valid, first-tile init, final-tile last)
//   skew_latency  : cycles from row acceptance to appearance on a lane
// ----------------------------------------------------------------------------
package ia_pkg;

    typedef struct packed {
        logic valid;
        logic init;
        logic last;
    } lane_tag_t;

    // Lane i sees a row accepted at cycle t at cycle t+1+i: one cycle for the
    // input register plus i cycles of skew.
    function automatic int skew_latency(input int lane);
        return lane + 1;
    endfunction

endpackage

// File: rtl/ia_lane_delay.sv
// ----------------------------------------------------------------------------
// ia_lane_delay
// Fixed-depth shift register carrying one lane's data word and its tag.
// DEPTH=0 collapses to a wire so lane 0 needs no extra register.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   data_in     : lane data entering the delay line
//   tag_in      : valid/init/last qualifiers travelling with data_in
//   data_out    : data_in delayed by DEPTH cycles
//   tag_out     : tag_in delayed by DEPTH cycles
// ----------------------------------------------------------------------------
module ia_lane_delay
    import ia_pkg::*;
#(
    parameter int DEPTH      = 0,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  lane_tag_t             tag_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output lane_tag_t             tag_out
);

    generate
        if (DEPTH == 0) begin : g_pass
            // Clock and reset are unused by a pass-through lane.
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst_n;
            assign data_out       = data_in;
            assign tag_out        = tag_in;
        end else begin : g_pipe
            logic [DEPTH-1:0][DATA_WIDTH-1:0] data_q, data_d;
            lane_tag_t [DEPTH-1:0]            tag_q, tag_d;

            always_comb begin
                data_d    = data_q;
                tag_d     = tag_q;
                data_d[0] = data_in;
                tag_d[0]  = tag_in;
                for (int k = 1; k < DEPTH; k++) begin
                    data_d[k] = data_q[k-1];
                    tag_d[k]  = tag_q[k-1];
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    data_q <= '0;
                    tag_q  <= '0;
                end else begin
                    data_q <= data_d;
                    tag_q  <= tag_d;
                end
            end

            assign data_out = data_q[DEPTH-1];
            assign tag_out  = tag_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/ia_skew_feeder.sv
// ----------------------------------------------------------------------------
// ia_skew_feeder
// Takes whole input-activation rows from the loader, optionally adds the
// configured zero-point offset, and skews them so lane i of the systolic
// array sees the row i cycles after lane 0. Tile completion is tracked with
// a tag chain so drain_done fires when the tile's last row leaves lane SIZE-1.
// Build option:
//   IA_SKEW_SAT_EN : offset sum saturates to the DATA_WIDTH signed range;
//                    when undefined the sum wraps (low DATA_WIDTH bits).
// Ports:
//   clk, rst_n              : clock, asynchronous active-low reset
//   init_cfg                : latch lhs_zp / ia_use_offset (only while idle)
//   lhs_zp, ia_use_offset   : signed offset and its enable
//   row_valid_in, row_in    : input row strobe and SIZE signed elements
//   init_in, calc_done_in   : row belongs to first / final tile
//   sending_done_in         : loader tile-complete pulse
//   lane_data               : skewed array inputs (0 when lane invalid)
//   lane_valid/init/last    : per-lane qualifiers
//   drain_done              : tile's last row has left lane SIZE-1
//   busy                    : rows or done tags still in flight
// ----------------------------------------------------------------------------
module ia_skew_feeder
    import ia_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int SIZE       = 16,
    parameter int REG_WIDTH  = 32
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             init_cfg,
    input  logic [REG_WIDTH-1:0]             lhs_zp,
    input  logic                             ia_use_offset,
    input  logic                             row_valid_in,
    input  logic [SIZE-1:0][DATA_WIDTH-1:0]  row_in,
    input  logic                             init_in,
    input  logic                             calc_done_in,
    input  logic                             sending_done_in,
    output logic [SIZE-1:0][DATA_WIDTH-1:0]  lane_data,
    output logic [SIZE-1:0]                  lane_valid,
    output logic [SIZE-1:0]                  lane_init,
    output logic [SIZE-1:0]                  lane_last,
    output logic                             drain_done,
    output logic                             busy
);

    localparam int SUM_W = REG_WIDTH + 1;
    localparam int CNT_W = $clog2(SIZE + 1);

    localparam logic signed [SUM_W-1:0] SAT_MAX =
        {{(SUM_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] SAT_MIN =
        {{(SUM_W-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    logic [REG_WIDTH-1:0]            cfg_lhs_zp_q, cfg_lhs_zp_d;
    logic                            cfg_use_offset_q, cfg_use_offset_d;
    logic [SIZE-1:0][DATA_WIDTH-1:0] stage_data_q, stage_data_d;
    lane_tag_t                       stage_tag_q, stage_tag_d;
    logic [CNT_W-1:0]                inflight_q, inflight_d;
    logic [SIZE-1:0]                 done_q, done_d;
    logic signed [SUM_W-1:0]         offset_ext;
    logic signed [SUM_W-1:0]         elem_sum [SIZE];
    lane_tag_t                       lane_tag [SIZE];

    // Bring the offset sum back to lane width: clamp or two's-complement wrap.
    function automatic logic [DATA_WIDTH-1:0] reduce_sum(input logic signed [SUM_W-1:0] s);
`ifdef IA_SKEW_SAT_EN
        if (s > SAT_MAX) begin
            return SAT_MAX[DATA_WIDTH-1:0];
        end else if (s < SAT_MIN) begin
            return SAT_MIN[DATA_WIDTH-1:0];
        end
        return s[DATA_WIDTH-1:0];
`else
        return s[DATA_WIDTH-1:0];
`endif
    endfunction

    assign busy = (inflight_q != '0) || (done_q != '0);

    // Input stage: offset-add every element, zero data and tags on bubbles so
    // invalid lane cycles always present 0 to the array.
    always_comb begin
        offset_ext   = cfg_use_offset_q ? SUM_W'($signed(cfg_lhs_zp_q)) : '0;
        stage_data_d = '0;
        stage_tag_d  = '0;
        for (int i = 0; i < SIZE; i++) begin
            elem_sum[i] = SUM_W'($signed(row_in[i])) + offset_ext;
            if (row_valid_in) begin
                stage_data_d[i] = reduce_sum(elem_sum[i]);
            end
        end
        if (row_valid_in) begin
            stage_tag_d.valid = 1'b1;
            stage_tag_d.init  = init_in;
            stage_tag_d.last  = calc_done_in;
        end
    end

    // Configuration may only change while nothing is in flight, so every row
    // of a tile sees the same offset.
    always_comb begin
        cfg_lhs_zp_d     = cfg_lhs_zp_q;
        cfg_use_offset_d = cfg_use_offset_q;
        if (init_cfg && !busy && !row_valid_in) begin
            cfg_lhs_zp_d     = lhs_zp;
            cfg_use_offset_d = ia_use_offset;
        end
    end

    // In-flight row count and the tile-done tag chain. One tag bit per cycle
    // of latency means back-to-back done pulses never merge.
    always_comb begin
        inflight_d = inflight_q;
        if (row_valid_in && !lane_valid[SIZE-1]) begin
            inflight_d = inflight_q + CNT_W'(1);
        end else if (!row_valid_in && lane_valid[SIZE-1]) begin
            inflight_d = inflight_q - CNT_W'(1);
        end
        done_d = (done_q << 1) | SIZE'(sending_done_in);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_lhs_zp_q     <= '0;
            cfg_use_offset_q <= 1'b0;
            stage_data_q     <= '0;
            stage_tag_q      <= '0;
            inflight_q       <= '0;
            done_q           <= '0;
        end else begin
            cfg_lhs_zp_q     <= cfg_lhs_zp_d;
            cfg_use_offset_q <= cfg_use_offset_d;
            stage_data_q     <= stage_data_d;
            stage_tag_q      <= stage_tag_d;
            inflight_q       <= inflight_d;
            done_q           <= done_d;
        end
    end

    assign drain_done = done_q[SIZE-1];

    generate
        for (genvar i = 0; i < SIZE; i++) begin : g_lane
            ia_lane_delay #(
                .DEPTH      (skew_latency(i) - 1),
                .DATA_WIDTH (DATA_WIDTH)
            ) u_delay (
                .clk      (clk),
                .rst_n    (rst_n),
                .data_in  (stage_data_q[i]),
                .tag_in   (stage_tag_q),
                .data_out (lane_data[i]),
                .tag_out  (lane_tag[i])
            );
            assign lane_valid[i] = lane_tag[i].valid;
            assign lane_init[i]  = lane_tag[i].init;
            assign lane_last[i]  = lane_tag[i].last;
        end
    endgenerate

endmodule

// File: tb/tb_ia_skew_feeder.sv
// ----------------------------------------------------------------------------
// tb_ia_skew_feeder
// Drives ia_skew_feeder with directed and randomized rows and compares every
// output, every cycle, against a history-based reference model: a row taken
// in cycle r is expected on lane i in cycle r+1+i, a done pulse in cycle s is
// expected on drain_done in cycle s+SIZE.
// ----------------------------------------------------------------------------
module tb_ia_skew_feeder;

    localparam int SIZE = 16;
    localparam int DW   = 16;
    localparam int RW   = 32;
    localparam int MAXC = 2048;

    typedef logic [SIZE-1:0][DW-1:0] row_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          init_cfg = 1'b0;
    logic [RW-1:0] lhs_zp = '0;
    logic          ia_use_offset = 1'b0;
    logic          row_valid_in = 1'b0;
    row_t          row_in = '0;
    logic          init_in = 1'b0;
    logic          calc_done_in = 1'b0;
    logic          sending_done_in = 1'b0;
    row_t          lane_data;
    logic [SIZE-1:0] lane_valid, lane_init, lane_last;
    logic          drain_done, busy;

    always #5 clk = ~clk;

    ia_skew_feeder #(.DATA_WIDTH(DW), .SIZE(SIZE), .REG_WIDTH(RW)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .init_cfg        (init_cfg),
        .lhs_zp          (lhs_zp),
        .ia_use_offset   (ia_use_offset),
        .row_valid_in    (row_valid_in),
        .row_in          (row_in),
        .init_in         (init_in),
        .calc_done_in    (calc_done_in),
        .sending_done_in (sending_done_in),
        .lane_data       (lane_data),
        .lane_valid      (lane_valid),
        .lane_init       (lane_init),
        .lane_last       (lane_last),
        .drain_done      (drain_done),
        .busy            (busy)
    );

    int     checks = 0;
    int     failures = 0;
    int     cyc = 0;
    int     drain_seen = 0;
    bit     hv  [MAXC];
    bit     hi  [MAXC];
    bit     hl  [MAXC];
    bit     hsd [MAXC];
    row_t   hd  [MAXC];
    longint m_zp = 0;
    bit     m_use = 1'b0;

    task automatic checkOutput(input string tag, input logic [SIZE*DW-1:0] obs,
                               input logic [SIZE*DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    // Rows or done pulses seen in the last SIZE cycles are still in flight.
    function automatic bit modelBusy(input int c);
        for (int r = c - SIZE; r < c; r++) begin
            if (r >= 0 && (hv[r] || hsd[r])) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic [DW-1:0] modelReduce(input longint s);
        logic [63:0] bits;
`ifdef IA_SKEW_SAT_EN
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
`endif
        bits = s;
        return bits[DW-1:0];
    endfunction

    task automatic checkCycle();
        row_t            ed;
        logic [SIZE-1:0] ev, ei, el;
        logic            edr;
        ed = '0; ev = '0; ei = '0; el = '0;
        for (int i = 0; i < SIZE; i++) begin
            int r = cyc - 1 - i;
            if (r >= 0 && hv[r]) begin
                ed[i] = hd[r][i];
                ev[i] = 1'b1;
                ei[i] = hi[r];
                el[i] = hl[r];
            end
        end
        edr = (cyc >= SIZE) && hsd[cyc-SIZE];
        if (drain_done === 1'b1) drain_seen++;
        checkOutput("lane_data", lane_data, ed);
        checkOutput("lane_valid", lane_valid, ev);
        checkOutput("lane_init", lane_init, ei);
        checkOutput("lane_last", lane_last, el);
        checkOutput("drain_done", drain_done, edr);
        checkOutput("busy", busy, modelBusy(cyc));
    endtask

    // One clock cycle: check the outputs, then present this cycle's inputs
    // and record what the model expects them to cause.
    task automatic applyStimulus(input bit v, input row_t row, input bit ini, input bit lst,
                                 input bit sd, input bit cfg, input logic [RW-1:0] zp,
                                 input bit use_off, input bit rn);
        @(negedge clk);
        if (cyc >= MAXC) begin
            $display("[TB] FAIL cycle_budget observed=%0d expected<%0d", cyc, MAXC);
            $fatal(1, "[TB] cycle budget exhausted");
        end
        checkCycle();
        rst_n           = rn;
        row_valid_in    = v;
        row_in          = row;
        init_in         = ini;
        calc_done_in    = lst;
        sending_done_in = sd;
        init_cfg        = cfg;
        lhs_zp          = zp;
        ia_use_offset   = use_off;
        hv[cyc] = 1'b0; hi[cyc] = 1'b0; hl[cyc] = 1'b0; hsd[cyc] = 1'b0; hd[cyc] = '0;
        if (!rn) begin
            for (int k = 0; k < cyc; k++) begin
                hv[k]  = 1'b0;
                hsd[k] = 1'b0;
            end
            m_zp  = 0;
            m_use = 1'b0;
        end else begin
            hv[cyc]  = v;
            hi[cyc]  = v & ini;
            hl[cyc]  = v & lst;
            hsd[cyc] = sd;
            if (v) begin
                for (int i = 0; i < SIZE; i++) begin
                    longint e = longint'($signed(row[i]));
                    hd[cyc][i] = modelReduce(e + (m_use ? m_zp : 0));
                end
            end
            if (cfg && !v && !modelBusy(cyc)) begin
                m_zp  = longint'($signed(zp));
                m_use = use_off;
            end
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) applyStimulus(0, '0, 0, 0, 0, 0, '0, 0, 1);
    endtask

    task automatic sendRow(input row_t row, input bit ini, input bit lst, input bit sd);
        applyStimulus(1, row, ini, lst, sd, 0, '0, 0, 1);
    endtask

    task automatic setCfg(input logic [RW-1:0] zp, input bit use_off);
        applyStimulus(0, '0, 0, 0, 0, 1, zp, use_off, 1);
    endtask

    function automatic row_t fillRow(input logic [DW-1:0] val);
        row_t r;
        for (int i = 0; i < SIZE; i++) r[i] = val;
        return r;
    endfunction

    function automatic row_t randRow();
        row_t r;
        for (int i = 0; i < SIZE; i++) r[i] = DW'($urandom);
        return r;
    endfunction

    initial begin
        int d0;
        $display("[TB] start");

        // Held in reset: everything quiet.
        for (int k = 0; k < 3; k++) applyStimulus(0, '0, 0, 0, 0, 0, '0, 0, 0);
        idle(2);

        // Single row of 5s, offset off.
        sendRow(fillRow(16'd5), 1, 1, 0);
        idle(20);

        // Sixteen back-to-back rows, done with the last one.
        d0 = drain_seen;
        for (int k = 0; k < 16; k++) sendRow(randRow(), k < 8, k == 15, k == 15);
        idle(20);
        checkOutput("drain_count_tile", drain_seen - d0, 1);

        // Offset cancels exactly, then pushes the positive extreme over.
        setCfg(32'd128, 1);
        sendRow(fillRow(16'hFF80), 0, 0, 0);
        idle(20);
        setCfg(32'd1, 1);
        sendRow(fillRow(16'h7FFF), 0, 0, 0);
        sendRow(fillRow(16'h8000), 0, 0, 0);
        idle(20);
        setCfg(32'hFFFF_FFFF, 1);
        sendRow(fillRow(16'h8000), 0, 0, 0);
        idle(20);

        // Two done pulses two cycles apart must both come out.
        setCfg(32'd1, 1);
        d0 = drain_seen;
        for (int k = 0; k < 6; k++) begin
            applyStimulus(k < 4, randRow(), 0, 0, (k == 3) || (k == 5), 0, '0, 0, 1);
        end
        idle(20);
        checkOutput("drain_count_two_tiles", drain_seen - d0, 2);

        // Configuration while busy is ignored, accepted once idle.
        sendRow(randRow(), 0, 0, 0);
        setCfg(32'd7, 1);
        sendRow(fillRow(16'd0), 0, 0, 0);
        idle(20);
        setCfg(32'd7, 1);
        sendRow(fillRow(16'd0), 0, 0, 0);
        idle(20);

        // Randomized traffic with occasional reconfiguration attempts.
        for (int k = 0; k < 200; k++) begin
            bit v = ($urandom_range(0, 2) != 0) && ((k / 25) % 2 == 0);
            bit cfg = ($urandom_range(0, 7) == 0);
            logic [RW-1:0] zp = RW'($urandom_range(0, 131071)) - RW'(65536);
            applyStimulus(v, randRow(), $urandom_range(0, 1), $urandom_range(0, 1),
                          $urandom_range(0, 9) == 0, cfg && !v, zp, $urandom_range(0, 1), 1);
        end
        idle(20);

        // Reset mid-stream kills rows and a pending done pulse.
        for (int k = 0; k < 8; k++) sendRow(randRow(), 1, 0, k == 2);
        d0 = drain_seen;
        applyStimulus(1, randRow(), 0, 0, 0, 0, '0, 0, 0);
        applyStimulus(0, '0, 0, 0, 0, 0, '0, 0, 0);
        idle(25);
        checkOutput("drain_count_after_reset", drain_seen - d0, 0);

        // Recovery after reset, offset back to off.
        sendRow(randRow(), 1, 1, 1);
        idle(20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
